// File: rtl/wb_dest_scoreboard.sv
// Register-bank destination scoreboard: selects the write destination at issue, queues it in order, commits on completion.
// Latency: a completion strobe pops the head at the edge; the bank write (reg_write/write_reg) appears one cycle later.
// Backpressure: issue_ready drops when the pending FIFO is full; a pop in the same cycle does not free a slot for that cycle's issue.
//
// Ports:
//   clk, reset                    rising-edge clock, asynchronous active-low reset
//   issue_valid/issue_ready       enqueue handshake; dest_sel picks rt/rd/rs/SP_REG/RA_REG (5-7 illegal)
//   rt, rd, rs                    instruction register fields
//   wb_valid                      oldest pending op has completed
//   src_a, src_b, hazard          RAW hazard query against outstanding destinations
//   reg_write, write_reg          registered bank write port
//   pending                       FIFO occupancy, err sticky illegal-select / underflow flag
module wb_dest_scoreboard #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4,
  parameter int SP_REG = 29,
  parameter int RA_REG = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [2:0]              dest_sel,
  input  logic [REG_AW-1:0]       rt,
  input  logic [REG_AW-1:0]       rd,
  input  logic [REG_AW-1:0]       rs,
  input  logic                    wb_valid,
  input  logic [REG_AW-1:0]       src_a,
  input  logic [REG_AW-1:0]       src_b,
  output logic                    hazard,
  output logic                    reg_write,
  output logic [REG_AW-1:0]       write_reg,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage: address, zero flag and a per-slot valid bit used by the hazard search
  logic [REG_AW-1:0] addr_q [DEPTH];
  logic [DEPTH-1:0]  zf_q;
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;

  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic              err_q, err_d;

  logic [REG_AW-1:0] issue_addr;
  logic              sel_legal;
  logic              issue_fire;
  logic              push;
  logic              pop;
  logic              hit_a, hit_b;

  // Destination select decode
  always_comb begin
    issue_addr = '0;
    case (dest_sel)
      3'd0:    issue_addr = rt;
      3'd1:    issue_addr = rd;
      3'd2:    issue_addr = rs;
      3'd3:    issue_addr = REG_AW'(SP_REG);
      3'd4:    issue_addr = REG_AW'(RA_REG);
      default: issue_addr = '0;
    endcase
  end

  assign sel_legal   = (dest_sel <= 3'd4);
  assign issue_ready = (count_q != CW'(DEPTH));
  assign issue_fire  = issue_valid && issue_ready;
  assign push        = issue_fire && sel_legal;
  assign pop         = wb_valid && (count_q != '0);

  // Next-state for counter, write port and sticky error
  always_comb begin
    count_d     = count_q;
    reg_write_d = 1'b0;
    write_reg_d = write_reg_q;
    err_d       = err_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop) begin
      write_reg_d = addr_q[rd_ptr_q];
      // Writes to $0 still move the address but never strobe the bank
      reg_write_d = ~zf_q[rd_ptr_q];
    end
    if (issue_fire && !sel_legal) err_d = 1'b1;
    if (wb_valid && (count_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
      zf_q        <= '0;
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // Push and pop never touch the same slot: equal pointers with both
      // active would need a full FIFO (push blocked) or an empty one (pop blocked).
      if (push) begin
        addr_q[wr_ptr_q] <= issue_addr;
        zf_q[wr_ptr_q]   <= (issue_addr == '0);
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      err_q       <= err_d;
    end
  end

  // Hazard search over queued entries plus the write committing this cycle.
  // Only registered state is consulted, so wb_valid never reaches hazard combinationally.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == src_a)) hit_a = 1'b1;
      if (vld_q[i] && (addr_q[i] == src_b)) hit_b = 1'b1;
    end
    if (reg_write_q && (write_reg_q == src_a)) hit_a = 1'b1;
    if (reg_write_q && (write_reg_q == src_b)) hit_b = 1'b1;
    hazard = (hit_a && (src_a != '0)) || (hit_b && (src_b != '0));
  end

  assign reg_write = reg_write_q;
  assign write_reg = write_reg_q;
  assign pending   = count_q;
  assign err       = err_q;

endmodule
